// File: rtl/mont_domain_conv.sv
// Montgomery domain converter.
// Bit-serial radix-2 Montgomery product MonPro(X, Y) = X*Y*R^-1 mod N, with R = 2^DATA_LENGTH.
//   dir=0: Y = R^2 mod N, so the result is X*R mod N (into the Montgomery domain).
//   dir=1: Y = 1, so the result is X*R^-1 mod N (out of the Montgomery domain).
// Each ITER clock consumes one multiplier bit, LSB first.
// An even modulus has no inverse of 2, so the product is skipped and the request is flagged with err.
module mont_domain_conv #(
  parameter int DATA_LENGTH = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dir,
  input  logic [DATA_LENGTH-1:0] X_in,
  input  logic [DATA_LENGTH-1:0] M_r,
  input  logic [DATA_LENGTH-1:0] R_t,
  output logic [DATA_LENGTH-1:0] X_out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int N  = DATA_LENGTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FINAL} state_t;

  state_t         state_reg;
  logic [N-1:0]   xr_reg;        // multiplier; shifted right so bit 0 is the current bit
  logic [N-1:0]   yr_reg;        // multiplicand: R^2 mod N or 1
  logic [N-1:0]   nr_reg;        // modulus
  logic [N+1:0]   a_reg;         // accumulator; stays below 2N, and the two spare bits absorb A+Y+N
  logic [CW-1:0]  cnt_reg;
  logic           err_pend_reg;  // request had an even modulus

  logic [N+1:0]   a_add_y;
  logic [N+1:0]   a_add_n;
  logic [N+1:0]   a_next;
  logic [N-1:0]   a_sub;
  logic           a_ge_n;

  // One Montgomery step plus the final conditional subtraction.
  always_comb begin
    a_add_y = a_reg + (xr_reg[0] ? {2'b00, yr_reg} : '0);
    a_add_n = a_add_y[0] ? (a_add_y + {2'b00, nr_reg}) : a_add_y;
    a_next  = a_add_n >> 1;
    a_ge_n  = (a_reg >= {2'b00, nr_reg});
    a_sub   = a_reg[N-1:0] - nr_reg;   // only the low n bits of A-N are needed
  end

  // Control FSM with operand registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      xr_reg       <= '0;
      yr_reg       <= '0;
      nr_reg       <= '0;
      a_reg        <= '0;
      cnt_reg      <= '0;
      err_pend_reg <= 1'b0;
      X_out        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            xr_reg       <= X_in;
            yr_reg       <= dir ? {{(N-1){1'b0}}, 1'b1} : R_t;
            nr_reg       <= M_r;
            a_reg        <= '0;
            cnt_reg      <= '0;
            busy         <= 1'b1;
            err_pend_reg <= ~M_r[0];
            state_reg    <= M_r[0] ? ITER : FINAL;
          end
        end
        ITER: begin
          a_reg   <= a_next;
          xr_reg  <= xr_reg >> 1;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(N - 1)) begin
            state_reg <= FINAL;
          end
        end
        FINAL: begin
          if (err_pend_reg) begin
            X_out <= '0;
            err   <= 1'b1;
          end else begin
            X_out <= a_ge_n ? a_sub : a_reg[N-1:0];
            err   <= 1'b0;
          end
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
